reg_bus_master: RTL and testbench



---
 rtl/reg_bus_master.sv | 205 ++++++++++++++++++++
 tb/tb_reg_bus_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
// reg_bus_master: bus initiator for the peripheral register bank.
// Core-side requests are queued in a small FIFO. A single FSM then runs one
// register-bank transaction at a time. Each request produces exactly one
// response, which is held until the core consumes it.
module reg_bus_master #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_ADDR = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_wben,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  bus_addr,
  output logic [3:0]  bus_wben,
  output logic        bus_r_wn,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic        write;
    logic [3:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_CAPT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // FIFO storage and control
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  entry_t        head_s;
  logic          addr_err_s;

  // FSM and registered outputs
  state_t        state_q,     state_d;
  logic [3:0]    bus_addr_q,  bus_addr_d;
  logic [3:0]    bus_wben_q,  bus_wben_d;
  logic          bus_r_wn_q,  bus_r_wn_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic          rsp_err_q,   rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  assign full_s     = (count_q == (PW+1)'(DEPTH));
  assign empty_s    = (count_q == (PW+1)'(0));
  assign push_s     = req_valid && !full_s;
  assign head_s     = fifo_q[rd_ptr_q];
  assign addr_err_s = (head_s.addr > 4'(MAX_ADDR));

  assign req_ready  = !full_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wben   = bus_wben_q;
  assign bus_r_wn   = bus_r_wn_q;
  assign bus_wdata  = bus_wdata_q;

  // Request payload storage; no reset needed because count_q qualifies every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {req_write, req_addr, req_wben, req_wdata};
    end
  end

  // FIFO pointers and occupancy; reset drops every queued request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and next-output decode; the bus is in read mode except during WR
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wben_d  = 4'h0;
    bus_r_wn_d  = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_write_d = head_s.write;
          rsp_err_d   = addr_err_s;
          rsp_rdata_d = 32'h0;
          if (addr_err_s) begin
            // Unmapped address: no bus strobe, go straight to the response
            state_d = S_RESP;
          end else if (head_s.write) begin
            state_d     = S_WR;
            bus_addr_d  = head_s.addr;
            bus_wben_d  = head_s.wben;
            bus_wdata_d = head_s.wdata;
            bus_r_wn_d  = 1'b0;
          end else begin
            state_d    = S_RD_ADDR;
            bus_addr_d = head_s.addr;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RD_ADDR: begin
        // Bank registers rdata at the end of this cycle
        state_d = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        state_d     = S_RESP;
        rsp_rdata_d = bus_rdata;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          // Error responses enter RESP one cycle before valid is raised
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces read mode so no partial write escapes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_addr_q  <= 4'h0;
      bus_wben_q  <= 4'h0;
      bus_r_wn_q  <= 1'b1;
      bus_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_wben_q  <= bus_wben_d;
      bus_r_wn_q  <= bus_r_wn_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Testbench for reg_bus_master: register bank model plus in-order response scoreboard.
module tb_reg_bus_master;

  localparam int MAX_ADDR = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [3:0]  req_wben;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  bus_addr;
  logic [3:0]  bus_wben;
  logic        bus_r_wn;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  reg_bus_master #(.DEPTH(2), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wben(req_wben), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_wben(bus_wben), .bus_r_wn(bus_r_wn),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic        w;
    logic        e;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bank   [16];
  logic [31:0] shadow [16];
  logic        bank_init;
  int          cyc = 0;
  int          strobes = 0;
  int          push_cyc;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  // Register bank model: byte-enabled writes, rdata registered one cycle after addr
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_init) begin
      for (int i = 0; i < 16; i++) bank[i] <= init_val(i);
    end else if (!bus_r_wn) begin
      strobes <= strobes + 1;
      for (int b = 0; b < 4; b++)
        if (bus_wben[b]) bank[bus_addr][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
    bus_rdata <= bank[bus_addr];
  end

  // Drive one request; optionally record its expected response on the scoreboard
  task automatic push(input logic w, input logic [3:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic track);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wben = be; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL push_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    #1;
    push_cyc  = cyc;
    req_valid = 1'b0;
    if (track) begin
      x.w = w;
      x.e = (a > 4'(MAX_ADDR));
      x.d = 32'h0;
      if (!x.e) begin
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end else begin
          x.d = shadow[a];
        end
      end
      exp_q.push_back(x);
    end
  endtask

  // Wait (bounded) for a response, consume it and report what was seen
  task automatic get_rsp(output logic ok, output logic w, output logic e,
                         output logic [31:0] d, output int lat);
    int n;
    n = 0; ok = 1'b0; w = 1'b0; e = 1'b0; d = 32'h0; lat = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid) begin
      ok = 1'b1; w = rsp_write; e = rsp_err; d = rsp_rdata; lat = cyc - push_cyc;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bank_init = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wben = 4'h0; req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    repeat (3) @(negedge clk);
    bank_init = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_write, rsp_err, bus_r_wn, bus_wben} !== 9'b1_0_0_0_1_0000) begin
      bad++;
      $display("FAIL reset_ctrl: rdy/v/w/e/rwn/wben=%b required 100010000",
               {req_ready, rsp_valid, rsp_write, rsp_err, bus_r_wn, bus_wben});
    end
    total++;
    if ({rsp_rdata, bus_addr, bus_wdata} !== 68'h0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required all 0", rsp_rdata, bus_addr, bus_wdata);
    end
  endtask

  task automatic test_write();
    logic ok, w, e; logic [31:0] d; int lat; int s0; exp_t x;
    s0 = strobes;
    push(1'b1, 4'd6, 4'hF, 32'hDEADBEEF, 1'b1);
    @(negedge clk); @(negedge clk);
    total++;
    if ({bus_r_wn, bus_addr, bus_wben, bus_wdata} !== {1'b0, 4'd6, 4'hF, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL write_bus: rwn=%b addr=%h wben=%h wdata=%h required 0 6 f deadbeef",
               bus_r_wn, bus_addr, bus_wben, bus_wdata);
    end
    get_rsp(ok, w, e, d, lat);
    x = exp_q.pop_front();
    total++;
    if (!ok || {w, e, d} !== {x.w, x.e, x.d}) begin
      bad++;
      $display("FAIL write_rsp: ok=%b w=%b e=%b d=%h required w=%b e=%b d=%h", ok, w, e, d, x.w, x.e, x.d);
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL write_latency: got %0d required 2", lat); end
    total++;
    if (strobes - s0 !== 1) begin bad++; $display("FAIL write_strobes: got %0d required 1", strobes - s0); end
    total++;
    if (bus_r_wn !== 1'b1) begin bad++; $display("FAIL write_rwn_after: got %b required 1", bus_r_wn); end
  endtask

  task automatic test_read(input logic [3:0] a, input string name);
    logic ok, w, e; logic [31:0] d; int lat; exp_t x;
    push(1'b0, a, 4'h0, 32'h0, 1'b1);
    get_rsp(ok, w, e, d, lat);
    x = exp_q.pop_front();
    total++;
    if (!ok || {w, e, d} !== {x.w, x.e, x.d}) begin
      bad++;
      $display("FAIL %s_rsp: ok=%b w=%b e=%b d=%h required w=%b e=%b d=%h", name, ok, w, e, d, x.w, x.e, x.d);
    end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL %s_latency: got %0d required 3", name, lat); end
  endtask

  task automatic test_partial_write();
    logic ok, w, e; logic [31:0] d; int lat; exp_t x;
    push(1'b1, 4'd6, 4'b0010, 32'h0000AB00, 1'b1);
    get_rsp(ok, w, e, d, lat);
    x = exp_q.pop_front();
    total++;
    if (!ok || {w, e, d} !== {x.w, x.e, x.d}) begin
      bad++;
      $display("FAIL partial_rsp: ok=%b w=%b e=%b d=%h required w=%b e=%b d=%h", ok, w, e, d, x.w, x.e, x.d);
    end
    test_read(4'd6, "partial_readback");
  endtask

  task automatic test_error(input logic wr, input logic [3:0] a);
    logic ok, w, e; logic [31:0] d; int lat; int s0; exp_t x;
    s0 = strobes;
    push(wr, a, 4'hF, 32'hFFFF_FFFF, 1'b1);
    get_rsp(ok, w, e, d, lat);
    x = exp_q.pop_front();
    total++;
    if (!ok || {w, e, d} !== {x.w, x.e, x.d}) begin
      bad++;
      $display("FAIL error_rsp: ok=%b w=%b e=%b d=%h required w=%b e=%b d=%h", ok, w, e, d, x.w, x.e, x.d);
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL error_latency: got %0d required 2", lat); end
    total++;
    if (strobes - s0 !== 0 || bus_r_wn !== 1'b1) begin
      bad++;
      $display("FAIL error_no_strobe: strobes=%0d rwn=%b required 0 1", strobes - s0, bus_r_wn);
    end
  endtask

  task automatic test_wben_zero();
    logic ok, w, e; logic [31:0] d; int lat; int s0; exp_t x;
    s0 = strobes;
    push(1'b1, 4'd2, 4'h0, 32'hFFFF_FFFF, 1'b1);
    get_rsp(ok, w, e, d, lat);
    x = exp_q.pop_front();
    total++;
    if (!ok || {w, e, d} !== {x.w, x.e, x.d} || strobes - s0 !== 1) begin
      bad++;
      $display("FAIL wben0_rsp: ok=%b w=%b e=%b d=%h strobes=%0d required w=%b e=%b d=%h strobes=1",
               ok, w, e, d, strobes - s0, x.w, x.e, x.d);
    end
    test_read(4'd2, "wben0_readback");
  endtask

  task automatic test_back_to_back();
    logic ok, w, e; logic [31:0] d; int lat; exp_t x;
    rsp_ready = 1'b0;
    push(1'b0, 4'd6, 4'h0, 32'h0, 1'b1);
    push(1'b0, 4'd2, 4'h0, 32'h0, 1'b1);
    push(1'b0, 4'd3, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: req_ready=%b required 0", req_ready); end
    repeat (10) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_hold: req_ready=%b rsp_valid=%b required 0 1", req_ready, rsp_valid);
    end
    for (int k = 0; k < 3; k++) begin
      get_rsp(ok, w, e, d, lat);
      x = exp_q.pop_front();
      total++;
      if (!ok || {w, e, d} !== {x.w, x.e, x.d}) begin
        bad++;
        $display("FAIL b2b_rsp%0d: ok=%b w=%b e=%b d=%h required w=%b e=%b d=%h", k, ok, w, e, d, x.w, x.e, x.d);
      end
    end
    total++;
    if (req_ready !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: req_ready=%b pending=%0d required 1 0", req_ready, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int s0;
    s0 = strobes;
    push(1'b1, 4'd3, 4'hF, 32'h1234_5678, 1'b0);
    @(negedge clk); @(negedge clk);
    total++;
    if (bus_r_wn !== 1'b0) begin bad++; $display("FAIL rst_mid_in_wr: rwn=%b required 0", bus_r_wn); end
    reset = 1'b1;
    #1;
    total++;
    if ({bus_r_wn, bus_wben} !== 5'b1_0000) begin
      bad++;
      $display("FAIL rst_mid_bus: rwn=%b wben=%h required 1 0", bus_r_wn, bus_wben);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        bad++;
        $display("FAIL rst_mid_idle%0d: rsp_valid=%b req_ready=%b required 0 1", k, rsp_valid, req_ready);
      end
    end
    total++;
    if (strobes - s0 !== 0) begin bad++; $display("FAIL rst_mid_strobes: got %0d required 0", strobes - s0); end
    test_read(4'd3, "rst_mid_readback");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(4'd6, "read");
    test_partial_write();
    test_error(1'b0, 4'd13);
    test_error(1'b1, 4'd15);
    test_wben_zero();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
